// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Serialises an 8-bit word into an 11-bit asynchronous frame:
//   start (0), 8 data bits LSB-first, parity, stop (1).
// Bit timing matches the companion UART receiver. Each bit lasts OVERSAMPLE
// sample ticks. A sample tick is one clk cycle in every "div" cycles, and div
// is selected by baud_select when a word is accepted.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   reset        in   synchronous, active-high reset
//   baud_select  in   [2:0] baud rate select, latched on acceptance
//   Tx_EN        in   enable; gates acceptance of new words only
//   Tx_WR        in   write strobe; accepted when Tx_EN=1 and Tx_BUSY=0
//   Tx_DATA      in   [7:0] parallel word to send
//   TxD          out  registered serial line, idles high
//   Tx_BUSY      out  high while a frame is in flight
//   Tx_DONE      out  one-cycle pulse when the stop bit completes
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter bit ODD_PARITY = 1'b0,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Index of the last sample tick within a bit period.
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    // clk cycles per sample tick for each baud_select code.
    function automatic logic [13:0] baud_divisor(input logic [2:0] sel);
        logic [13:0] div;
        case (sel)
            3'b000:  div = 14'd10417;
            3'b001:  div = 14'd2604;
            3'b010:  div = 14'd651;
            3'b011:  div = 14'd326;
            3'b100:  div = 14'd163;
            3'b101:  div = 14'd81;
            3'b110:  div = 14'd54;
            3'b111:  div = 14'd27;
            default: div = 14'd27;
        endcase
        return div;
    endfunction

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic frame_parity(input logic [7:0] data);
        return (^data) ^ ODD_PARITY;
    endfunction

    state_e      state_q,    state_d;
    logic [13:0] div_q,      div_d;
    logic [13:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]  sample_q,   sample_d;
    logic [2:0]  bit_idx_q,  bit_idx_d;
    logic [7:0]  data_q,     data_d;
    logic        parity_q,   parity_d;
    logic        txd_q,      txd_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    logic        accept_s;
    logic        tick_s;
    logic        bit_end_s;
    logic [2:0]  next_idx_s;

    // Acceptance and bit-timing strobes.
    always_comb begin
        accept_s   = Tx_WR && Tx_EN && !busy_q && (state_q == ST_IDLE);
        tick_s     = (state_q != ST_IDLE) && (tick_cnt_q == (div_q - 14'd1));
        bit_end_s  = tick_s && (sample_q == LAST_SAMPLE);
        next_idx_s = bit_idx_q + 3'd1;
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        sample_d   = sample_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        parity_d   = parity_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Tick and sample counters only run while a frame is in flight; they
        // wrap to zero naturally at the end of the stop bit.
        if (state_q != ST_IDLE) begin
            if (tick_s) begin
                tick_cnt_d = 14'd0;
                sample_d   = sample_q + 4'd1;
            end else begin
                tick_cnt_d = tick_cnt_q + 14'd1;
            end
        end else begin
            tick_cnt_d = 14'd0;
            sample_d   = 4'd0;
        end

        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (accept_s) begin
                    state_d   = ST_START;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                    data_d    = Tx_DATA;
                    parity_d  = frame_parity(Tx_DATA);
                    div_d     = baud_divisor(baud_select);
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = data_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
                    end else begin
                        bit_idx_d = next_idx_s;
                        txd_d     = data_q[next_idx_s];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset returns the line to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_q      <= 14'd0;
            tick_cnt_q <= 14'd0;
            sample_q   <= 4'd0;
            bit_idx_q  <= 3'd0;
            data_q     <= 8'd0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            sample_q   <= sample_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;
    assign Tx_DONE = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD, Tx_BUSY, Tx_DONE;
    logic       TxD_odd, busy_odd, done_odd;

    int checks = 0;
    int errors = 0;

    uart_transmitter #(.ODD_PARITY(1'b0), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .baud_select(baud_select), .Tx_EN(Tx_EN),
        .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .TxD(TxD), .Tx_BUSY(Tx_BUSY),
        .Tx_DONE(Tx_DONE)
    );

    uart_transmitter #(.ODD_PARITY(1'b1), .OVERSAMPLE(16)) dut_odd (
        .clk(clk), .reset(reset), .baud_select(baud_select), .Tx_EN(Tx_EN),
        .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .TxD(TxD_odd), .Tx_BUSY(busy_odd),
        .Tx_DONE(done_odd)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] baud;
        int         div;
        logic       par_e;
        logic       par_o;
        bit         disturb;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Idle line check over n cycles.
    task automatic idle_check(input string name, input int n);
        bit bad;
        bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) bad = 1'b1;
        end
        chk(name, {31'd0, bad}, 32'd0);
    endtask

    // Request a write at the current negedge; the next posedge accepts it.
    task automatic start_write(input logic [7:0] data, input logic [2:0] baud);
        Tx_DATA     = data;
        baud_select = baud;
        Tx_EN       = 1'b1;
        Tx_WR       = 1'b1;
    endtask

    // Follow one frame from its accepting edge to the Tx_DONE cycle.
    task automatic watch_frame(input string name, input logic [7:0] data, input int div,
                               input logic par_e, input logic par_o, input bit disturb,
                               input bit chain, input logic [7:0] chain_data);
        int bl, total, busy_cnt;
        logic prev, tx;
        bit glitch, early_done;
        logic [10:0] got_e, got_o, exp_e, exp_o;
        bl = 16 * div;
        total = 176 * div;
        busy_cnt = 0;
        glitch = 1'b0;
        early_done = 1'b0;
        got_e = 11'h0;
        got_o = 11'h0;
        exp_e = {1'b1, par_e, data, 1'b0};
        exp_o = {1'b1, par_o, data, 1'b0};
        @(posedge clk);
        @(negedge clk);
        Tx_WR = 1'b0;
        prev = 1'b1;
        for (int i = 0; i <= total; i++) begin
            tx = TxD;
            if (i < total) begin
                if (Tx_BUSY === 1'b1) busy_cnt++;
                if (Tx_DONE !== 1'b0) early_done = 1'b1;
                if (tx !== prev && (i % bl) != 0) glitch = 1'b1;
                if ((i % bl) == bl / 2) begin
                    got_e[i / bl] = tx;
                    got_o[i / bl] = TxD_odd;
                end
                prev = tx;
                if (disturb && i == 1000) begin
                    Tx_DATA = 8'h3C; baud_select = 3'b000; Tx_EN = 1'b1; Tx_WR = 1'b1;
                end
                if (disturb && i == 1001) Tx_WR = 1'b0;
                if (disturb && i == 2000) Tx_EN = 1'b0;
                @(negedge clk);
            end else begin
                chk({name, " done"}, {31'd0, Tx_DONE}, 32'd1);
                chk({name, " busy_end"}, {31'd0, Tx_BUSY}, 32'd0);
                chk({name, " txd_end"}, {31'd0, tx}, 32'd1);
                Tx_EN = 1'b1;
                if (disturb) baud_select = 3'b111;
                if (chain) begin
                    Tx_DATA = chain_data;
                    Tx_WR   = 1'b1;
                end
            end
        end
        chk({name, " bits"}, {21'd0, got_e}, {21'd0, exp_e});
        chk({name, " bits_odd"}, {21'd0, got_o}, {21'd0, exp_o});
        chk({name, " busy_cycles"}, busy_cnt, total);
        chk({name, " early_done"}, {31'd0, early_done}, 32'd0);
        chk({name, " glitch"}, {31'd0, glitch}, 32'd0);
        if (!chain) begin
            @(negedge clk);
            chk({name, " done_one_cycle"}, {31'd0, Tx_DONE}, 32'd0);
            idle_check({name, " idle_after"}, 100);
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, baud: 3'b111, div: 27, par_e: 1'b0, par_o: 1'b1, disturb: 1'b1};
        vecs[1] = '{data: 8'h01, baud: 3'b111, div: 27, par_e: 1'b1, par_o: 1'b0, disturb: 1'b0};
        vecs[2] = '{data: 8'hFF, baud: 3'b111, div: 27, par_e: 1'b0, par_o: 1'b1, disturb: 1'b0};
        vecs[3] = '{data: 8'h80, baud: 3'b111, div: 27, par_e: 1'b1, par_o: 1'b0, disturb: 1'b0};

        reset = 1'b1; baud_select = 3'b111; Tx_EN = 1'b0; Tx_WR = 1'b0; Tx_DATA = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset txd", {31'd0, TxD}, 32'd1);
        chk("reset busy", {31'd0, Tx_BUSY}, 32'd0);
        chk("reset done", {31'd0, Tx_DONE}, 32'd0);
        reset = 1'b0;
        idle_check("idle 1000", 1000);

        // Write strobe with the transmitter disabled is ignored.
        Tx_EN = 1'b0; Tx_WR = 1'b1; Tx_DATA = 8'h3C;
        repeat (5) @(negedge clk);
        Tx_WR = 1'b0;
        idle_check("wr with en=0", 200);

        for (int v = 0; v < 4; v++) begin
            start_write(vecs[v].data, vecs[v].baud);
            watch_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].div,
                        vecs[v].par_e, vecs[v].par_o, vecs[v].disturb, 1'b0, 8'h00);
        end

        // Back-to-back: 0x55 requested in the Tx_DONE cycle of 0xA5.
        start_write(8'hA5, 3'b111);
        watch_frame("b2b first", 8'hA5, 27, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
        watch_frame("b2b second", 8'h55, 27, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Reset during D3 at baud_select=110, together with a write strobe.
        start_write(8'hC3, 3'b110);
        @(posedge clk);
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (4 * 864 + 432) @(negedge clk);
        chk("pre-reset d3", {31'd0, TxD}, 32'd0);
        chk("pre-reset busy", {31'd0, Tx_BUSY}, 32'd1);
        reset = 1'b1; Tx_WR = 1'b1; Tx_DATA = 8'h5A;
        @(negedge clk);
        chk("midreset txd", {31'd0, TxD}, 32'd1);
        chk("midreset busy", {31'd0, Tx_BUSY}, 32'd0);
        chk("midreset done", {31'd0, Tx_DONE}, 32'd0);
        reset = 1'b0; Tx_WR = 1'b0;
        idle_check("after reset+wr", 50);

        start_write(8'h5A, 3'b110);
        watch_frame("post-reset 110", 8'h5A, 54, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
